alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised, handshaked successor to the combinational ALU decoder. Decodes the full RV32I integer ALU operation set from ALUOp/funct3/funct7b5, executes it on XLEN-bit operands, and returns a registered result through a valid/ready interface. Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle. The block sits in the execute stage between operand mux and writeback register.

## Interface
- XLEN, 32: operand/result width; power of two, ≥8.
- SHIFT_STEP, 1: bits shifted per iteration; power of two, 1..XLEN. SHIFT_STEP == XLEN selects single-cycle shifts.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort; drops in-flight op and pending result.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready at rising edge.
- ALUOp  input  2  00 ADD, 01 SUB, 10 R-type, 11 I-type arithmetic.
- funct3  input  3  instruction funct3.
- funct7b5  input  1  instruction bit 30.
- SrcA  input  XLEN  operand A.
- SrcB  input  XLEN  operand B / immediate; shamt = SrcB[log2(XLEN)-1:0].
- out_valid  output  1  Result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- Result  output  XLEN  registered result.
- Zero  output  1  registered (Result == 0).

## Operation
- Internal 4-bit op: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, SLTU 0101, XOR 0110, SLL 0111, SRL 1000, SRA 1001.
- ALUOp 00 → ADD; 01 → SUB (funct fields ignored).
- ALUOp 10: funct3 000 → SUB if funct7b5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → SRA if funct7b5 else SRL; 110 OR; 111 AND.
- ALUOp 11: identical except funct3 000 is always ADD (funct7b5 ignored).
- ADD/SUB wrap modulo 2^XLEN. SLT signed, SLTU unsigned; result is zero-extended 0/1.
- FSM states IDLE, SHIFT.
  - IDLE: in_ready = !out_valid || out_ready. On accept: non-shift op, shamt == 0, or SHIFT_STEP == XLEN → compute, load Result/Zero, out_valid=1, stay IDLE. Otherwise load working reg = SrcA, rem = shamt, → SHIFT.
  - SHIFT: in_ready=0. Each edge shifts working reg by min(SHIFT_STEP, rem) (SLL zero-fill left; SRL zero-fill right; SRA sign-fill right) and decrements rem by that amount. On the edge where rem reaches 0: load Result/Zero, out_valid=1, → IDLE.
- Output: out_valid clears on out_valid && out_ready, unless a new result loads on the same edge (then stays 1 with new data).
- flush: takes priority over everything; next edge → IDLE, out_valid=0, rem=0; in_valid ignored that cycle. Result/Zero keep old values.

## Timing
- Reset values: state IDLE, out_valid 0, Result 0, Zero 0, rem 0; in_ready 1 out of reset.
- Latency (accept edge to out_valid high): 1 cycle for non-shift, shamt 0, or SHIFT_STEP == XLEN; otherwise 1 + ceil(shamt / SHIFT_STEP).
- Throughput: one op per cycle for single-cycle ops when out_ready is held high.
- Back-pressure: out_valid && !out_ready → in_ready=0; Result/Zero stable.
- SHIFT is entered only with an empty or draining output register, so completion never overwrites an unconsumed result.
- in_ready is combinational from state, out_valid, and out_ready; no combinational path from in_valid to any output.
- rst_n assertion mid-SHIFT: immediate return to reset values; no result produced.

## Test plan
- XLEN=32, STEP=1: reset, then ALUOp=10, f3=000, f7b5=1, A=5, B=7 → one cycle later Result=0xFFFFFFFE, Zero=0; same with ALUOp=11 → Result=12.
- STEP=4: SRA (ALUOp=10, f3=101, f7b5=1), A=0x80000000, B=9 → out_valid after 1+3=4 cycles, Result=0xFFC00000; in_ready low while shifting.
- SLTU vs SLT: A=0xFFFFFFFF, B=1 → SLTU Result=0, SLT Result=1; SUB A=B=0x1234 → Result=0, Zero=1.
- Back-pressure: out_ready=0 for 3 cycles after an ADD → Result held, in_ready=0; raise out_ready with a new in_valid → back-to-back accept, out_valid stays 1 with new data.
- STEP=1: SLL A=1, B=31 mid-shift (cycle 10): flush=1 → out_valid stays 0, in_ready=1 next cycle. Repeat with rst_n pulse → all outputs at reset values.
- Shift shamt=0 (SRL A=0xA5, B=0x20) → latency 1, Result=0xA5. STEP=32: SLL B=31 → latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I-style integer ALU for the execute stage.
// Decodes ALUOp/funct3/funct7b5 into an internal op and executes it on
// XLEN-bit operands. The result is registered and returned through a
// valid/ready output port. Shifts run on an iterative shifter that moves
// SHIFT_STEP bits per cycle. SHIFT_STEP == XLEN makes every shift single-cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds its payload stable while valid is high and not yet
// accepted. in_ready depends only on state, out_valid and out_ready, so there
// is no combinational path from in_valid to any output. out_valid and
// Result/Zero are held until out_ready.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            state_dbg
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    localparam logic [SHW:0] STEP_L = (SHW+1)'(SHIFT_STEP);
    localparam logic ONE_CYCLE_SHIFT = (SHIFT_STEP == XLEN);

    logic [0:0]      state;
    logic [3:0]      op;
    logic [3:0]      op_q;
    logic [XLEN-1:0] work;
    logic [SHW-1:0]  rem;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic            single;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic [SHW:0]    rem_ext;
    logic [SHW:0]    step_amt;
    logic [XLEN-1:0] shifted;
    logic            last_step;

    assign shamt     = SrcB[SHW-1:0];
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign state_dbg = state;

    // Decode the instruction fields into the internal op.
    always_comb begin
        op = OP_ADD;
        case (ALUOp)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                case (funct3)
                    3'b000: op = (funct7b5 && (ALUOp == 2'b10)) ? OP_SUB : OP_ADD;
                    3'b001: op = OP_SLL;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: op = funct7b5 ? OP_SRA : OP_SRL;
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
        endcase
    end

    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign single   = !is_shift || (shamt == '0) || ONE_CYCLE_SHIFT;

    // Single-cycle datapath; shifts here use the full shamt.
    always_comb begin
        alu_res = SrcA + SrcB;
        case (op)
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL:  alu_res = SrcA << shamt;
            OP_SRL:  alu_res = SrcA >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(SrcA) >>> shamt);
            default: alu_res = SrcA + SrcB;
        endcase
    end

    // One iteration of the multi-cycle shifter: move by min(SHIFT_STEP, rem).
    always_comb begin
        rem_ext   = {1'b0, rem};
        step_amt  = (rem_ext < STEP_L) ? rem_ext : STEP_L;
        last_step = (rem_ext == step_amt);
        case (op_q)
            OP_SLL:  shifted = work << step_amt;
            OP_SRA:  shifted = $unsigned($signed(work) >>> step_amt);
            default: shifted = work >> step_amt;
        endcase
    end

    // Control FSM, output register and shifter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            rem       <= '0;
            work      <= '0;
            op_q      <= OP_ADD;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rem       <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (single) begin
                            Result    <= alu_res;
                            Zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end else begin
                            work  <= SrcA;
                            rem   <= shamt;
                            op_q  <= op;
                            state <= SHIFT;
                        end
                    end
                end
                default: begin
                    work <= shifted;
                    rem  <= rem - step_amt[SHW-1:0];
                    if (last_step) begin
                        Result    <= shifted;
                        Zero      <= (shifted == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
